// File: rtl/espi_mux_sel_ctl.sv
// espi_mux_sel_ctl
// Multi-channel eSPI / strap mux select controller. Each channel synchronises
// one platform reset input, qualifies each edge against the 1 us tick with an
// independent assert/deassert delay, and drives a registered mux select with a
// firmware override and a one-clock change strobe.

module espi_mux_sel_ctl #(
    parameter int CHANNELS     = 2,
    parameter int CNT_BITS     = 8,
    parameter int ASSERT_DLY   = 2,
    parameter int DEASSERT_DLY = 0
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                i1uSCE,
    input  logic [CHANNELS-1:0] iSignal,
    input  logic [CHANNELS-1:0] iForceEn,
    input  logic [CHANNELS-1:0] iForceVal,
    output logic [CHANNELS-1:0] oSel,
    output logic [CHANNELS-1:0] oSelChange,
    output logic [CHANNELS-1:0] oQualBusy
);

    localparam int CNT_MAX = (1 << CNT_BITS) - 1;

    // Terminal counter values: the edge qualifies on the tick that would bring
    // the count to DLY, i.e. while the counter still holds DLY-1.
    localparam logic [CNT_BITS-1:0] ASSERT_LAST   = CNT_BITS'((ASSERT_DLY   > 0) ? ASSERT_DLY   - 1 : 0);
    localparam logic [CNT_BITS-1:0] DEASSERT_LAST = CNT_BITS'((DEASSERT_DLY > 0) ? DEASSERT_DLY - 1 : 0);
    localparam logic [CNT_BITS-1:0] CNT_SAT       = '1;

    // Refuse to build with parameters the counter cannot represent.
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("espi_mux_sel_ctl: CHANNELS must be in 1..8");
    end
    if (CNT_BITS < 1 || CNT_BITS > 30) begin : g_bad_cnt_bits
        $error("espi_mux_sel_ctl: CNT_BITS must be in 1..30");
    end
    if (ASSERT_DLY < 0 || ASSERT_DLY > CNT_MAX) begin : g_bad_assert_dly
        $error("espi_mux_sel_ctl: ASSERT_DLY exceeds 2^CNT_BITS-1");
    end
    if (DEASSERT_DLY < 0 || DEASSERT_DLY > CNT_MAX) begin : g_bad_deassert_dly
        $error("espi_mux_sel_ctl: DEASSERT_DLY exceeds 2^CNT_BITS-1");
    end

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        QUAL_HIGH   = 2'd1,
        ACTIVE_HIGH = 2'd2,
        QUAL_LOW    = 2'd3
    } state_t;

    // Counter increment that holds at full scale instead of wrapping.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_BITS'(1);
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch

        logic                sync1_q;
        logic                sync2_q;
        state_t              state_q;
        state_t              state_d;
        logic [CNT_BITS-1:0] cnt_q;
        logic [CNT_BITS-1:0] cnt_d;
        logic                sel_q;
        logic                sel_d;
        logic                chg_q;
        logic                busy_q;
        logic                busy_d;
        logic                fsm_val_d;

        // Two-flop synchroniser bringing the asynchronous input into iClk.
        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= iSignal[c];
                sync2_q <= sync1_q;
            end
        end

        // Next-state and next-output decode for the qualification FSM.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE_LOW: begin
                    if (sync2_q) begin
                        if (ASSERT_DLY == 0) begin
                            state_d = ACTIVE_HIGH;
                        end else begin
                            state_d = QUAL_HIGH;
                        end
                        cnt_d = '0;
                    end
                end
                QUAL_HIGH: begin
                    if (!sync2_q) begin
                        // Input dropped before the window closed: glitch.
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                    end else if (i1uSCE) begin
                        if (cnt_q == ASSERT_LAST) begin
                            state_d = ACTIVE_HIGH;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = sat_inc(cnt_q);
                        end
                    end
                end
                ACTIVE_HIGH: begin
                    if (!sync2_q) begin
                        if (DEASSERT_DLY == 0) begin
                            state_d = IDLE_LOW;
                        end else begin
                            state_d = QUAL_LOW;
                        end
                        cnt_d = '0;
                    end
                end
                QUAL_LOW: begin
                    if (sync2_q) begin
                        state_d = ACTIVE_HIGH;
                        cnt_d   = '0;
                    end else if (i1uSCE) begin
                        if (cnt_q == DEASSERT_LAST) begin
                            state_d = IDLE_LOW;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = sat_inc(cnt_q);
                        end
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end
            endcase

            // The select follows the FSM's view of the line; a pending
            // deassert keeps it high until the low is qualified.
            fsm_val_d = (state_d == ACTIVE_HIGH) || (state_d == QUAL_LOW);
            busy_d    = (state_d == QUAL_HIGH)   || (state_d == QUAL_LOW);
            // The override only masks the output; the FSM keeps tracking so
            // releasing it lands on the current qualified value directly.
            sel_d     = iForceEn[c] ? iForceVal[c] : fsm_val_d;
        end

        // FSM state, counter and registered outputs share one clock edge.
        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                state_q <= IDLE_LOW;
                cnt_q   <= '0;
                sel_q   <= 1'b0;
                chg_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                sel_q   <= sel_d;
                chg_q   <= (sel_d != sel_q);
                busy_q  <= busy_d;
            end
        end

        assign oSel[c]       = sel_q;
        assign oSelChange[c] = chg_q;
        assign oQualBusy[c]  = busy_q;
    end

endmodule

// File: tb/tb_espi_mux_sel_ctl.sv
// Bench for espi_mux_sel_ctl: two instances (default-like 2-channel and a
// 4-channel one with asymmetric delays) checked every cycle against an
// edge-qualification reference model, plus directed latency scenarios.

module tb_espi_mux_sel_ctl;

    localparam int A_CH = 2, A_CB = 8, A_AD = 2, A_DD = 1;
    localparam int B_CH = 4, B_CB = 2, B_AD = 3, B_DD = 0;

    logic clk = 1'b0;
    logic rst_n;
    logic tick;

    logic [A_CH-1:0] sigA, feA, fvA, selA, chgA, busyA;
    logic [B_CH-1:0] sigB, feB, fvB, selB, chgB, busyB;

    int n_chk  = 0;
    int n_fail = 0;
    int tick_per = 50;
    int tick_ctr = 0;
    bit rnd_tick = 1'b0;

    always #5 clk = ~clk;

    espi_mux_sel_ctl #(.CHANNELS(A_CH), .CNT_BITS(A_CB), .ASSERT_DLY(A_AD), .DEASSERT_DLY(A_DD)) u_dut_a (
        .iClk(clk), .iRst_n(rst_n), .i1uSCE(tick),
        .iSignal(sigA), .iForceEn(feA), .iForceVal(fvA),
        .oSel(selA), .oSelChange(chgA), .oQualBusy(busyA)
    );

    espi_mux_sel_ctl #(.CHANNELS(B_CH), .CNT_BITS(B_CB), .ASSERT_DLY(B_AD), .DEASSERT_DLY(B_DD)) u_dut_b (
        .iClk(clk), .iRst_n(rst_n), .i1uSCE(tick),
        .iSignal(sigB), .iForceEn(feB), .iForceVal(fvB),
        .oSel(selB), .oSelChange(chgB), .oQualBusy(busyB)
    );

    // ---------------- reference model ----------------
    // Per channel: the qualified level, whether the synchronised input
    // currently disagrees with it (an edge is pending), and how many ticks
    // have been seen since that disagreement began.
    typedef struct packed {
        logic       val;
        logic       pend;
        logic [7:0] ticks;
    } mch_t;

    function automatic mch_t mstep(mch_t c, logic s, logic tk, int adly, int ddly);
        mch_t n = c;
        int   need = c.val ? ddly : adly;
        if (s == c.val) begin
            n.pend  = 1'b0;
            n.ticks = '0;
        end else if (!c.pend) begin
            if (need == 0) n.val = s;
            else begin
                n.pend  = 1'b1;
                n.ticks = '0;
            end
        end else if (tk) begin
            n.ticks = c.ticks + 8'd1;
            if (int'(n.ticks) == need) begin
                n.val   = s;
                n.pend  = 1'b0;
                n.ticks = '0;
            end
        end
        return n;
    endfunction

    mch_t mA [A_CH];
    mch_t mB [B_CH];
    logic [A_CH-1:0] mA_s1, mA_s2, mA_sel, mA_chg;
    logic [B_CH-1:0] mB_s1, mB_s2, mB_sel, mB_chg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mA_s1 <= '0; mA_s2 <= '0; mA_sel <= '0; mA_chg <= '0;
            mB_s1 <= '0; mB_s2 <= '0; mB_sel <= '0; mB_chg <= '0;
            for (int i = 0; i < A_CH; i++) mA[i] <= '0;
            for (int i = 0; i < B_CH; i++) mB[i] <= '0;
        end else begin
            mA_s1 <= sigA; mA_s2 <= mA_s1;
            mB_s1 <= sigB; mB_s2 <= mB_s1;
            for (int i = 0; i < A_CH; i++) begin
                mA[i]     <= mstep(mA[i], mA_s2[i], tick, A_AD, A_DD);
                mA_sel[i] <= feA[i] ? fvA[i] : mstep(mA[i], mA_s2[i], tick, A_AD, A_DD).val;
                mA_chg[i] <= (feA[i] ? fvA[i] : mstep(mA[i], mA_s2[i], tick, A_AD, A_DD).val) != mA_sel[i];
            end
            for (int i = 0; i < B_CH; i++) begin
                mB[i]     <= mstep(mB[i], mB_s2[i], tick, B_AD, B_DD);
                mB_sel[i] <= feB[i] ? fvB[i] : mstep(mB[i], mB_s2[i], tick, B_AD, B_DD).val;
                mB_chg[i] <= (feB[i] ? fvB[i] : mstep(mB[i], mB_s2[i], tick, B_AD, B_DD).val) != mB_sel[i];
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: compare every output to the model at the falling
    // edge, then schedule the tick for the next rising edge.
    task automatic cyc();
        logic [A_CH-1:0] ebA;
        logic [B_CH-1:0] ebB;
        @(negedge clk);
        for (int i = 0; i < A_CH; i++) ebA[i] = mA[i].pend;
        for (int i = 0; i < B_CH; i++) ebB[i] = mB[i].pend;
        check_eq("A_sel",  32'(selA),  32'(mA_sel));
        check_eq("A_chg",  32'(chgA),  32'(mA_chg));
        check_eq("A_busy", 32'(busyA), 32'(ebA));
        check_eq("B_sel",  32'(selB),  32'(mB_sel));
        check_eq("B_chg",  32'(chgB),  32'(mB_chg));
        check_eq("B_busy", 32'(busyB), 32'(ebB));
        if (rnd_tick) begin
            tick = ($urandom_range(0, 3) == 0);
        end else begin
            tick_ctr++;
            if (tick_ctr >= tick_per) begin
                tick_ctr = 0;
                tick = 1'b1;
            end else begin
                tick = 1'b0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int  n;
    int  cnt_chg;
    bit  tk, bz, saw_busy, saw_chg;

    initial begin
        rst_n = 1'b0; tick = 1'b0;
        sigA = '0; feA = '0; fvA = '0;
        sigB = '0; feB = '0; fvB = '0;

        // Reset holds everything low even with inputs high.
        sigA = 2'b11;
        repeat (4) cyc();
        check_eq("rst_selA",  32'(selA),  0);
        check_eq("rst_chgA",  32'(chgA),  0);
        check_eq("rst_busyA", 32'(busyA), 0);
        check_eq("rst_selB",  32'(selB),  0);

        // Release: qualification starts on the 3rd edge, select after 2 ticks.
        rst_n = 1'b1; tick_ctr = 0;
        cyc(); cyc();
        check_eq("busy_pre", 32'(busyA), 0);
        cyc();
        check_eq("busy_on", 32'(busyA), 32'h3);
        n = 0;
        for (int i = 0; i < 300 && selA != 2'b11; i++) begin
            tk = tick; bz = busyA[0];
            cyc();
            if (tk && bz) n++;
        end
        check_eq("rise_selA", 32'(selA), 32'h3);
        check_eq("rise_ticks", n, A_AD);
        check_eq("rise_chgA", 32'(chgA), 32'h3);

        // Glitch shorter than two ticks is rejected on channel 0.
        sigA = 2'b00;
        repeat (150) cyc();
        check_eq("fall_selA", 32'(selA), 0);
        tick_ctr = 35;
        sigA[0] = 1'b1;
        saw_busy = 1'b0; saw_chg = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            saw_busy |= busyA[0];
            saw_chg  |= chgA[0] | selA[0];
        end
        sigA[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            saw_chg |= chgA[0] | selA[0];
        end
        check_eq("glitch_busy_seen", 32'(saw_busy), 1);
        check_eq("glitch_no_sel", 32'(saw_chg), 0);
        check_eq("glitch_busy_clr", 32'(busyA[0]), 0);

        // Asymmetric delays on B channel 0: three ticks up, three clocks down.
        sigB[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 400 && !selB[0]; i++) begin
            tk = tick; bz = busyB[0];
            cyc();
            if (tk && bz) n++;
        end
        check_eq("B_rise_sel", 32'(selB[0]), 1);
        check_eq("B_rise_ticks", n, B_AD);
        check_eq("B_rise_chg", 32'(chgB[0]), 1);
        cyc();
        check_eq("B_rise_chg_end", 32'(chgB[0]), 0);
        sigB[0] = 1'b0;
        cyc(); cyc();
        check_eq("B_fall_hold", 32'(selB[0]), 1);
        cyc();
        check_eq("B_fall_sel", 32'(selB[0]), 0);
        check_eq("B_fall_chg", 32'(chgB[0]), 1);
        cyc();
        check_eq("B_fall_chg_end", 32'(chgB[0]), 0);

        // Override on A channel 1 while the FSM keeps tracking underneath.
        sigA[1] = 1'b1;
        for (int i = 0; i < 300 && !selA[1]; i++) cyc();
        check_eq("ovr_pre_sel", 32'(selA[1]), 1);
        feA[1] = 1'b1; fvA[1] = 1'b0;
        cyc();
        check_eq("ovr_sel0", 32'(selA[1]), 0);
        check_eq("ovr_chg0", 32'(chgA[1]), 1);
        cnt_chg = 0;
        sigA[1] = 1'b0;
        for (int i = 0; i < 150; i++) begin cyc(); cnt_chg += int'(chgA[1]); end
        sigA[1] = 1'b1;
        for (int i = 0; i < 200; i++) begin cyc(); cnt_chg += int'(chgA[1]); end
        check_eq("ovr_quiet", cnt_chg, 0);
        feA[1] = 1'b0;
        cyc();
        check_eq("ovr_rel_sel", 32'(selA[1]), 1);
        check_eq("ovr_rel_chg", 32'(chgA[1]), 1);
        cyc();
        check_eq("ovr_rel_chg_end", 32'(chgA[1]), 0);

        // Reset in the middle of qualification, after one counted tick.
        sigA[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 300 && n < 1; i++) begin
            tk = tick; bz = busyA[0];
            cyc();
            if (tk && bz) n++;
        end
        check_eq("mid_one_tick", n, 1);
        check_eq("mid_busy", 32'(busyA[0]), 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sel",  32'(selA),  0);
        check_eq("mid_rst_chg",  32'(chgA),  0);
        check_eq("mid_rst_busy", 32'(busyA), 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 300 && !selA[0]; i++) begin
            tk = tick; bz = busyA[0];
            cyc();
            if (tk && bz) n++;
        end
        check_eq("mid_requal_sel", 32'(selA[0]), 1);
        check_eq("mid_requal_ticks", n, A_AD);

        // Channel independence on B: bits 0 and 3 together, 1 and 2 idle.
        repeat (5) cyc();
        sigB = 4'b1001;
        cnt_chg = 0;
        for (int i = 0; i < 400 && !(selB[0] || selB[3]); i++) begin
            cyc();
            cnt_chg += int'(chgB[1]) + int'(chgB[2]);
        end
        check_eq("ind_sel", 32'(selB), 32'h9);
        check_eq("ind_chg", 32'(chgB), 32'h9);
        check_eq("ind_quiet", cnt_chg, 0);

        // Randomised traffic with dense ticks, overrides and reset pulses.
        rnd_tick = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if ($urandom_range(0, 9) == 0) sigA[$urandom_range(0, A_CH-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) sigB[$urandom_range(0, B_CH-1)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0) begin
                feA = A_CH'($urandom_range(0, 3)) & A_CH'($urandom_range(0, 3));
                fvA = A_CH'($urandom_range(0, 3));
                feB = B_CH'($urandom_range(0, 15)) & B_CH'($urandom_range(0, 15));
                fvB = B_CH'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/espi_mux_sel_ctl.md
# espi_mux_sel_ctl

Parametrised, multi-channel successor to the two-channel eSPI mux selector. Each channel qualifies a platform reset/strap-sample input (RSMRST#, BMC SRST#, and others) against the 1 µs tick. Assertion and deassertion delays are independent, so each edge has its own delay, and glitches shorter than the qualification window are rejected. Each channel drives one mux select line, with a per-channel firmware/debug override and a change-strobe for sequencer logging. The block sits in the core CPLD between the reset inputs and the eSPI/strap mux select pins.

## Interface
- CHANNELS, 2, number of independent select channels (1–8)
- CNT_BITS, 8, qualification counter width; elaboration fails if ASSERT_DLY or DEASSERT_DLY exceeds 2^CNT_BITS−1
- ASSERT_DLY, 2, i1uSCE ticks the input must stay high before oSel rises (0 = no qualification)
- DEASSERT_DLY, 0, i1uSCE ticks the input must stay low before oSel falls (0 = no qualification)

Ports:
- iClk, in, 1, system clock
- iRst_n, in, 1, asynchronous active-low reset
- i1uSCE, in, 1, single-cycle 1 µs clock enable
- iSignal, in, CHANNELS, raw reset/strap inputs; asynchronous to iClk; bit n feeds channel n
- iForceEn, in, CHANNELS, per-channel override enable
- iForceVal, in, CHANNELS, per-channel override value
- oSel, out, CHANNELS, registered mux select outputs
- oSelChange, out, CHANNELS, one-clock pulse on every oSel transition
- oQualBusy, out, CHANNELS, high while the channel is in QUAL_HIGH or QUAL_LOW

## Operation
- Reset is asynchronous, active-low. On assertion, all flops clear: synchronisers=0, FSM=IDLE_LOW, counter=0, oSel=0, oSelChange=0, oQualBusy=0.
- Each iSignal bit passes through a 2-flop synchroniser. "s" below means the synchronised bit.
- Each channel has its own FSM with four states: IDLE_LOW, QUAL_HIGH, ACTIVE_HIGH, QUAL_LOW.
- IDLE_LOW, s=1:
  - ASSERT_DLY=0 → go to ACTIVE_HIGH.
  - Otherwise → go to QUAL_HIGH with cnt=0.
- QUAL_HIGH:
  - s=0 → return to IDLE_LOW with cnt=0 (glitch rejected; oSel never moved).
  - s=1 and i1uSCE and cnt==ASSERT_DLY−1 → go to ACTIVE_HIGH.
  - s=1 and i1uSCE, otherwise → cnt+1.
- ACTIVE_HIGH: mirror of IDLE_LOW, using s=0 and DEASSERT_DLY, with QUAL_LOW as the qualifying state.
- QUAL_LOW: mirror of QUAL_HIGH.
  - s=1 → return to ACTIVE_HIGH.
  - Qualification complete → go to IDLE_LOW.
- Tick counting: the counter counts only i1uSCE pulses. A tick landing on the same clock as QUAL entry is not counted.
- Counter behaviour: it never wraps. It saturates at 2^CNT_BITS−1 (unreachable with legal parameters).
- Output select:
  - FSM value = 1 in ACTIVE_HIGH or QUAL_LOW, else 0.
  - oSel_next = iForceEn ? iForceVal : FSM value.
- Override:
  - The FSM keeps tracking s while the override is active.
  - When the override is released, oSel_next returns to the current FSM value on the next clock. There is no requalification.
- oSelChange: set for one clock when oSel_next ≠ oSel. Registered on the same edge as oSel.
- Channels are fully independent. Simultaneous events on different channels are processed in the same cycle.

## Timing
- Synchroniser latency: s follows iSignal 2 clocks later. The FSM reacts on the 3rd edge.
- Assert latency with ASSERT_DLY=0: oSel rises on the 3rd rising edge after iSignal rises, with oSelChange high in that same cycle.
- Assert latency with ASSERT_DLY=N>0: oSel rises on the edge that samples the N-th i1uSCE pulse after QUAL_HIGH entry. The delay is N to N+1 µs plus 3 clocks.
- Deassert latency: same rules, using DEASSERT_DLY.
- Minimum accepted input pulse: the input must be held (in synchronised form) through ASSERT_DLY ticks. Anything shorter produces no oSel change and no oSelChange.
- Override path: iForceEn or iForceVal changes reach oSel 1 clock later. The inputs are not synchronised; they must come from the iClk domain.
- oQualBusy: registered, aligned with the FSM state.
- Reset mid-qualification: the channel clears immediately. After release, qualification restarts from IDLE_LOW.

## Test plan
- Reset values, defaults (CHANNELS=2, ASSERT_DLY=2): hold iRst_n=0 with iSignal=2'b11 → oSel=0, oSelChange=0, oQualBusy=0. Release → oQualBusy goes high, then oSel=2'b11 after the 2nd i1uSCE (i1uSCE every 50 clocks).
- Glitch rejection: raise iSignal[0] for 30 clocks with i1uSCE period 50 → oSel[0] stays 0, oSelChange stays 0, oQualBusy[0] pulses and then clears.
- Asymmetric delays (ASSERT_DLY=3, DEASSERT_DLY=0):
  - Rising input → oSel rises after the 3rd counted tick.
  - Falling input → oSel falls exactly 3 clocks after iSignal falls, with one oSelChange pulse each way.
- Override: channel 1 is ACTIVE_HIGH; set iForceEn[1]=1, iForceVal[1]=0 → oSel[1]=0 after 1 clock, with an oSelChange pulse. Drop iSignal[1], qualify, raise it again, then release the override → oSel[1]=1 after 1 clock, with no extra pulse beyond the single 0→1 change.
- Reset mid-qualification: assert iRst_n=0 during QUAL_HIGH with cnt=1 → all outputs are 0 immediately. After release, 2 full ticks are required again.
- Channel independence (CHANNELS=4): toggle bits 0 and 3 on the same clock → both qualify on the same edge. Bits 1 and 2 stay at 0, with no oSelChange.
